agree_predictor: RTL and testbench
==================================

Name: agree_predictor

Overview:
- Agree-mode branch predictor with BTB and bias bits.
- IF-stage side: combinational prediction (taken + target) for the fetch PC.
- EX-stage side: consumes the resolved branch decision alongside the branch resolution unit, raises redirect on mispredict, and updates BTB/PHT/GHR on the clock edge.
- Also keeps saturating branch/mispredict performance counters.

Parameters:
- BTB_IDX_W, 6, log2 of BTB entries; direct-mapped, indexed by pc[BTB_IDX_W+1:2].
- PHT_IDX_W, 8, log2 of PHT 2-bit counters.
- GHR_W, 8, global history length; must be <= PHT_IDX_W (elaboration assertion).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- if_pc_i  in  32  fetch PC
- if_pred_taken_o  out  1  predict taken
- if_pred_target_o  out  32  predicted target; if_pc_i+4 when not taken
- if_pht_idx_o  out  PHT_IDX_W  PHT index used; carried down the pipe
- ex_valid_i  in  1  EX holds a valid, non-flushed instruction
- ex_is_br_i  in  1  conditional branch
- ex_is_uncbr_i  in  1  jal/jalr
- ex_taken_i  in  1  resolved decision from BRU
- ex_pc_i  in  32  EX instruction PC
- ex_target_i  in  32  computed branch/jump target
- ex_pred_taken_i  in  1  prediction carried from IF
- ex_pred_target_i  in  32  predicted target carried from IF
- ex_pht_idx_i  in  PHT_IDX_W  index carried from IF
- redirect_o  out  1  mispredict; flush IF/ID, load redirect_pc_o
- redirect_pc_o  out  32  correct next PC
- br_cnt_o  out  32  resolved branches and jumps
- mispred_cnt_o  out  32  mispredicts

Behaviour:
- Storage:
  - BTB entry = {valid, tag pc[31:BTB_IDX_W+2], target[31:0], bias}.
  - PHT = 2-bit counters: 00 strong-disagree, 01 weak-disagree, 10 weak-agree, 11 strong-agree.
- Reset (async, immediate):
  - All BTB valid = 0; PHT counters = 2'b10; GHR = 0; both perf counters = 0.
  - Outputs are then: if_pred_taken_o = 0, if_pred_target_o = if_pc_i+4, redirect_o = 0, redirect_pc_o = 0.
  - No table write happens in a cycle where rst_i is high.
- Lookup (combinational, 0 latency):
  - hit = valid & tag match.
  - pht_idx = if_pc_i[PHT_IDX_W+1:2] XOR zero-extended GHR.
  - agree = counter[1].
  - if_pred_taken_o = hit & (bias XNOR agree).
- Resolve (combinational from EX inputs):
  - br = ex_valid_i & (ex_is_br_i | ex_is_uncbr_i).
  - correct_pc = ex_taken_i ? ex_target_i : ex_pc_i+4.
  - redirect_o = ex_valid_i & [ (br & ex_taken_i != ex_pred_taken_i) | (br & ex_taken_i & ex_pred_target_i != ex_target_i) | (!br & ex_pred_taken_i) ].
  - redirect_pc_o = correct_pc when redirect_o = 1, else 0.
- Update (rising edge, only when br = 1):
  - BTB miss:
    - Allocate: valid = 1, tag, target = ex_target_i, bias = ex_taken_i (uncbr: bias = 1).
    - No PHT update.
  - BTB hit, conditional:
    - PHT[ex_pht_idx_i] saturating +1 if ex_taken_i == bias, else -1. Holds at 11 and 00.
    - Target rewritten when ex_taken_i = 1.
  - BTB hit, unconditional: target rewritten; PHT untouched.
  - GHR = {GHR[GHR_W-2:0], ex_taken_i} for conditional branches only.
  - br_cnt_o += 1; mispred_cnt_o += redirect_o. Both saturate at 32'hFFFF_FFFF.
  - A non-branch with ex_pred_taken_i = 1 redirects to ex_pc_i+4 and counts as a mispredict. It does not modify the BTB.
- Simultaneous IF lookup and EX update on the same BTB/PHT entry: IF sees the pre-update value (no bypass).
- ex_valid_i = 0: no update, no redirect, regardless of the other EX inputs.

Decomposition:
- Shared package bp_pkg:
  - PHT state constants (SD=2'b00, WD=2'b01, WA=2'b10, SA=2'b11).
  - btb_entry_t struct.
  - Default widths.
- One natural sub-module: sat_counter2 (2-bit up/down saturating update function/module), reused for every PHT entry.

Test Plan:
- Reset mid-operation: assert rst_i between edges after several updates -> BTB lookups miss immediately, if_pred_taken_o = 0, GHR = 0, counters read 0.
- Cold conditional branch, pc 0x100 taken to 0x180:
  - First EX: redirect_o = 1, redirect_pc_o = 0x180; BTB allocated with bias = 1.
  - Next fetch of 0x100: if_pred_taken_o = 1, if_pred_target_o = 0x180.
- Agree training: same branch resolved not-taken twice -> PHT moves 10→01→00; fetch predicts not-taken (bias 1 XNOR agree 0) with target 0x104.
- PHT saturation: 5 consecutive agreeing outcomes -> counter stays 11; br_cnt_o increments by 5.
- jal at 0x200 → 0x400, then target changed to 0x480:
  - Second EX: redirect_o = 1 on target mismatch, BTB target updated, GHR unchanged.
- Non-branch at 0x300 with ex_pred_taken_i = 1 -> redirect_pc_o = 0x304; mispred_cnt_o += 1; BTB unchanged. Also drive the same-cycle same-index lookup/update and check that IF reads the old value.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and constants for the agree-mode branch predictor.
package bp_pkg;

    localparam int unsigned BTB_IDX_W_DEF = 6;
    localparam int unsigned PHT_IDX_W_DEF = 8;
    localparam int unsigned GHR_W_DEF     = 8;
    // Tag holds pc[31:BTB_IDX_W+2]; sized for the smallest index so any BTB_IDX_W fits.
    localparam int unsigned TAG_W         = 30;

    localparam logic [1:0] SD = 2'b00;
    localparam logic [1:0] WD = 2'b01;
    localparam logic [1:0] WA = 2'b10;
    localparam logic [1:0] SA = 2'b11;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        logic             bias;
    } btb_entry_t;

endpackage

// File: rtl/sat_counter2.sv
// 2-bit up/down saturating counter step used for PHT updates.
module sat_counter2
    import bp_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       inc,
    output logic [1:0] next_cnt_c
);

    always_comb begin
        next_cnt_c = cnt;
        if (inc) begin
            if (cnt != SA) next_cnt_c = cnt + 2'd1;
        end else begin
            if (cnt != SD) next_cnt_c = cnt - 2'd1;
        end
    end

endmodule

// File: rtl/agree_predictor.sv
// Agree-mode branch predictor: BTB with per-entry bias, PHT of agree counters,
// combinational IF lookup, EX resolve/redirect and clocked table training.
module agree_predictor
    import bp_pkg::*;
#(
    parameter int unsigned BTB_IDX_W = BTB_IDX_W_DEF,
    parameter int unsigned PHT_IDX_W = PHT_IDX_W_DEF,
    parameter int unsigned GHR_W     = GHR_W_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          if_pc_i,
    output logic                 if_pred_taken_o,
    output logic [31:0]          if_pred_target_o,
    output logic [PHT_IDX_W-1:0] if_pht_idx_o,
    input  logic                 ex_valid_i,
    input  logic                 ex_is_br_i,
    input  logic                 ex_is_uncbr_i,
    input  logic                 ex_taken_i,
    input  logic [31:0]          ex_pc_i,
    input  logic [31:0]          ex_target_i,
    input  logic                 ex_pred_taken_i,
    input  logic [31:0]          ex_pred_target_i,
    input  logic [PHT_IDX_W-1:0] ex_pht_idx_i,
    output logic                 redirect_o,
    output logic [31:0]          redirect_pc_o,
    output logic [31:0]          br_cnt_o,
    output logic [31:0]          mispred_cnt_o
);

    localparam int unsigned BTB_N     = 1 << BTB_IDX_W;
    localparam int unsigned PHT_N     = 1 << PHT_IDX_W;
    localparam int unsigned TAG_SHIFT = BTB_IDX_W + 2;

    if (GHR_W > PHT_IDX_W || GHR_W < 2) begin : g_cfg_check
        $error("agree_predictor: GHR_W must lie in [2, PHT_IDX_W]");
    end

    btb_entry_t       btb_q [BTB_N];
    logic [1:0]       pht_q [PHT_N];
    logic [GHR_W-1:0] ghr_q;
    logic [31:0]      br_cnt_q;
    logic [31:0]      mispred_cnt_q;

    logic [BTB_IDX_W-1:0] if_btb_idx;
    btb_entry_t           if_entry;
    logic                 if_hit;
    logic [PHT_IDX_W-1:0] if_pht_idx;

    // Fetch-side lookup reads the pre-update tables (no bypass from EX).
    always_comb begin
        if_btb_idx       = if_pc_i[BTB_IDX_W+1:2];
        if_entry         = btb_q[if_btb_idx];
        if_hit           = if_entry.valid && (if_entry.tag == TAG_W'(if_pc_i >> TAG_SHIFT));
        if_pht_idx       = if_pc_i[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr_q);
        if_pred_taken_o  = if_hit && (if_entry.bias == pht_q[if_pht_idx][1]);
        if_pred_target_o = if_pred_taken_o ? if_entry.target : if_pc_i + 32'd4;
    end

    assign if_pht_idx_o = if_pht_idx;

    logic [BTB_IDX_W-1:0] ex_btb_idx;
    logic [TAG_W-1:0]     ex_tag;
    btb_entry_t           ex_entry;
    btb_entry_t           ex_alloc;
    logic                 ex_hit;
    logic                 ex_br;
    logic                 ex_cond;
    logic                 ex_mispred;
    logic [31:0]          ex_correct_pc;
    logic [1:0]           pht_cur;
    logic [1:0]           pht_next;

    always_comb begin
        ex_btb_idx      = ex_pc_i[BTB_IDX_W+1:2];
        ex_tag          = TAG_W'(ex_pc_i >> TAG_SHIFT);
        ex_entry        = btb_q[ex_btb_idx];
        ex_hit          = ex_entry.valid && (ex_entry.tag == ex_tag);
        ex_br           = ex_valid_i && (ex_is_br_i || ex_is_uncbr_i);
        ex_cond         = ex_br && !ex_is_uncbr_i;
        ex_correct_pc   = ex_taken_i ? ex_target_i : ex_pc_i + 32'd4;
        ex_mispred      = (ex_br && (ex_taken_i != ex_pred_taken_i))
                       || (ex_br && ex_taken_i && (ex_pred_target_i != ex_target_i))
                       || (!ex_br && ex_pred_taken_i);
        // Reset masks redirect so the front end sees a quiet predictor.
        redirect_o      = !rst_i && ex_valid_i && ex_mispred;
        redirect_pc_o   = redirect_o ? ex_correct_pc : 32'd0;
        pht_cur         = pht_q[ex_pht_idx_i];
        ex_alloc.valid  = 1'b1;
        ex_alloc.tag    = ex_tag;
        ex_alloc.target = ex_target_i;
        ex_alloc.bias   = ex_is_uncbr_i || ex_taken_i;
    end

    // Counter moves toward agree when the outcome matches the entry's bias.
    sat_counter2 u_pht_step (
        .cnt        (pht_cur),
        .inc        (ex_taken_i == ex_entry.bias),
        .next_cnt_c (pht_next)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < BTB_N; i++) btb_q[i] <= '0;
            for (int unsigned i = 0; i < PHT_N; i++) pht_q[i] <= WA;
            ghr_q         <= '0;
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (ex_br) begin
                if (!ex_hit) begin
                    btb_q[ex_btb_idx] <= ex_alloc;
                end else begin
                    if (ex_cond) pht_q[ex_pht_idx_i] <= pht_next;
                    if (!ex_cond || ex_taken_i) btb_q[ex_btb_idx].target <= ex_target_i;
                end
                if (ex_cond) ghr_q <= {ghr_q[GHR_W-2:0], ex_taken_i};
                if (br_cnt_q != 32'hFFFF_FFFF) br_cnt_q <= br_cnt_q + 32'd1;
            end
            if (redirect_o && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
                mispred_cnt_q <= mispred_cnt_q + 32'd1;
            end
        end
    end

    assign br_cnt_o      = br_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_agree_predictor.sv
// Self-checking bench for agree_predictor: directed scenarios plus a randomized
// run compared against a behavioural model of the predictor tables.
module tb_agree_predictor;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] if_pc_i;
    logic        if_pred_taken_o;
    logic [31:0] if_pred_target_o;
    logic [7:0]  if_pht_idx_o;
    logic        ex_valid_i, ex_is_br_i, ex_is_uncbr_i, ex_taken_i;
    logic [31:0] ex_pc_i, ex_target_i, ex_pred_target_i;
    logic        ex_pred_taken_i;
    logic [7:0]  ex_pht_idx_i;
    logic        redirect_o;
    logic [31:0] redirect_pc_o, br_cnt_o, mispred_cnt_o;

    always #5 clk_i = ~clk_i;

    agree_predictor dut (
        .clk_i(clk_i), .rst_i(rst_i), .if_pc_i(if_pc_i),
        .if_pred_taken_o(if_pred_taken_o), .if_pred_target_o(if_pred_target_o),
        .if_pht_idx_o(if_pht_idx_o), .ex_valid_i(ex_valid_i), .ex_is_br_i(ex_is_br_i),
        .ex_is_uncbr_i(ex_is_uncbr_i), .ex_taken_i(ex_taken_i), .ex_pc_i(ex_pc_i),
        .ex_target_i(ex_target_i), .ex_pred_taken_i(ex_pred_taken_i),
        .ex_pred_target_i(ex_pred_target_i), .ex_pht_idx_i(ex_pht_idx_i),
        .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
        .br_cnt_o(br_cnt_o), .mispred_cnt_o(mispred_cnt_o)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: 64-entry BTB, 256 agree counters, 8-bit history.
    bit          mv    [64];
    logic [31:0] mtag  [64];
    logic [31:0] mtgt  [64];
    bit          mbias [64];
    int          pht   [256];
    int unsigned ghr;
    longint unsigned bc, mc;

    logic        obs_red, obs_if_tk;
    logic [31:0] obs_rpc, obs_if_tg;
    logic [7:0]  obs_if_idx;
    logic        exp_red;
    logic [31:0] exp_rpc;

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            mv[i] = 1'b0; mtag[i] = '0; mtgt[i] = '0; mbias[i] = 1'b0;
        end
        for (int i = 0; i < 256; i++) pht[i] = 2;
        ghr = 0; bc = 0; mc = 0;
    endtask

    function automatic logic [7:0] m_idx(input logic [31:0] pc);
        return 8'(((pc >> 2) ^ ghr) & 32'hFF);
    endfunction

    task automatic m_pred(input logic [31:0] pc, output logic tk, output logic [31:0] tg);
        int unsigned i;
        logic hit, agree;
        i     = (pc >> 2) & 63;
        hit   = mv[i] && (mtag[i] == (pc >> 8));
        agree = pht[m_idx(pc)] >= 2;
        tk    = hit && (mbias[i] == agree);
        tg    = tk ? mtgt[i] : pc + 32'd4;
    endtask

    task automatic m_update(input logic v, isbr, isunc, tk, input logic [31:0] pc, tgt,
                            input logic [7:0] pidx, input logic mis);
        int unsigned i;
        logic hit, cond;
        if (!v) return;
        if (mis && mc < 64'hFFFF_FFFF) mc++;
        if (!(isbr || isunc)) return;
        if (bc < 64'hFFFF_FFFF) bc++;
        cond = isbr && !isunc;
        i    = (pc >> 2) & 63;
        hit  = mv[i] && (mtag[i] == (pc >> 8));
        if (!hit) begin
            mv[i] = 1'b1; mtag[i] = pc >> 8; mtgt[i] = tgt; mbias[i] = isunc ? 1'b1 : tk;
        end else if (cond) begin
            if (tk == mbias[i]) pht[pidx] = (pht[pidx] == 3) ? 3 : pht[pidx] + 1;
            else                pht[pidx] = (pht[pidx] == 0) ? 0 : pht[pidx] - 1;
            if (tk) mtgt[i] = tgt;
        end else begin
            mtgt[i] = tgt;
        end
        if (cond) ghr = ((ghr << 1) | 32'(tk)) & 32'hFF;
    endtask

    // Drive one EX cycle, capture outputs before the edge, then advance model and DUT.
    task automatic ex_cycle(input logic v, isbr, isunc, tk, input logic [31:0] pc, tgt,
                            input logic ptk, input logic [31:0] ptgt, input logic [7:0] pidx);
        logic br;
        ex_valid_i = v; ex_is_br_i = isbr; ex_is_uncbr_i = isunc; ex_taken_i = tk;
        ex_pc_i = pc; ex_target_i = tgt; ex_pred_taken_i = ptk;
        ex_pred_target_i = ptgt; ex_pht_idx_i = pidx;
        #1;
        obs_red = redirect_o; obs_rpc = redirect_pc_o;
        obs_if_tk = if_pred_taken_o; obs_if_tg = if_pred_target_o; obs_if_idx = if_pht_idx_o;
        br = isbr || isunc;
        exp_red = v && (br ? ((tk != ptk) || (tk && ptgt != tgt)) : ptk);
        exp_rpc = exp_red ? (tk ? tgt : pc + 32'd4) : 32'd0;
        @(posedge clk_i);
        m_update(v, isbr, isunc, tk, pc, tgt, pidx, exp_red);
        #1;
        ex_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; if_pc_i = 32'h100;
        ex_valid_i = 1'b1; ex_is_br_i = 1'b1; ex_is_uncbr_i = 1'b0; ex_taken_i = 1'b1;
        ex_pc_i = 32'h100; ex_target_i = 32'h180; ex_pred_taken_i = 1'b0;
        ex_pred_target_i = 32'h104; ex_pht_idx_i = 8'h40;
        #1;
        checks++; if (if_pred_taken_o !== 1'b0) begin errors++; $display("FAIL reset_pred_taken got %0b exp 0", if_pred_taken_o); end
        checks++; if (if_pred_target_o !== 32'h104) begin errors++; $display("FAIL reset_pred_target got %h exp 00000104", if_pred_target_o); end
        checks++; if (redirect_o !== 1'b0 || redirect_pc_o !== 32'd0) begin errors++; $display("FAIL reset_redirect got %0b/%h exp 0/0", redirect_o, redirect_pc_o); end
        checks++; if (br_cnt_o !== 32'd0 || mispred_cnt_o !== 32'd0) begin errors++; $display("FAIL reset_counters got %0d/%0d exp 0/0", br_cnt_o, mispred_cnt_o); end
        @(posedge clk_i); #1;
        checks++; if (if_pred_taken_o !== 1'b0 || br_cnt_o !== 32'd0) begin errors++; $display("FAIL reset_no_write got taken %0b br %0d exp 0/0", if_pred_taken_o, br_cnt_o); end
        ex_valid_i = 1'b0;
        @(negedge clk_i); rst_i = 1'b0;
        model_reset();
        @(posedge clk_i); #1;
    endtask

    task automatic test_cold_branch();
        ex_cycle(1, 1, 0, 1, 32'h100, 32'h180, 0, 32'h104, m_idx(32'h100));
        checks++; if (obs_red !== 1'b1 || obs_rpc !== 32'h180) begin errors++; $display("FAIL cold_redirect got %0b/%h exp 1/00000180", obs_red, obs_rpc); end
        if_pc_i = 32'h100; #1;
        checks++; if (if_pred_taken_o !== 1'b1 || if_pred_target_o !== 32'h180) begin errors++; $display("FAIL cold_refetch got %0b/%h exp 1/00000180", if_pred_taken_o, if_pred_target_o); end
        checks++; if (br_cnt_o !== 32'd1 || mispred_cnt_o !== 32'd1) begin errors++; $display("FAIL cold_counters got %0d/%0d exp 1/1", br_cnt_o, mispred_cnt_o); end
    endtask

    task automatic test_agree_training();
        logic [7:0] k;
        k = 8'(((32'h100 >> 2) ^ (ghr << 2)) & 32'hFF);
        for (int n = 0; n < 2; n++) begin
            ex_cycle(1, 1, 0, 0, 32'h100, 32'h180, 1, 32'h180, k);
            checks++; if (obs_red !== 1'b1 || obs_rpc !== 32'h104) begin errors++; $display("FAIL train_redirect%0d got %0b/%h exp 1/00000104", n, obs_red, obs_rpc); end
        end
        if_pc_i = 32'h100; #1;
        checks++; if (if_pht_idx_o !== k) begin errors++; $display("FAIL train_idx got %h exp %h", if_pht_idx_o, k); end
        checks++; if (if_pred_taken_o !== 1'b0 || if_pred_target_o !== 32'h104) begin errors++; $display("FAIL train_disagree got %0b/%h exp 0/00000104", if_pred_taken_o, if_pred_target_o); end
    endtask

    task automatic test_pht_saturation();
        int unsigned g;
        logic [7:0] k;
        longint unsigned base;
        base = bc;
        g = ghr;
        for (int n = 0; n < 5; n++) g = ((g << 1) | 1) & 32'hFF;
        g = (g << 1) & 32'hFF;
        k = 8'((32'h40 ^ g) & 32'hFF);
        for (int n = 0; n < 5; n++) begin
            ex_cycle(1, 1, 0, 1, 32'h100, 32'h180, 1, 32'h180, k);
            checks++; if (obs_red !== 1'b0) begin errors++; $display("FAIL sat_agree%0d redirect got %0b exp 0", n, obs_red); end
        end
        checks++; if (br_cnt_o !== 32'(base + 5)) begin errors++; $display("FAIL sat_br_cnt got %0d exp %0d", br_cnt_o, base + 5); end
        ex_cycle(1, 1, 0, 0, 32'h100, 32'h180, 1, 32'h180, k);
        if_pc_i = 32'h100; #1;
        checks++; if (if_pred_taken_o !== 1'b1 || if_pred_target_o !== 32'h180) begin errors++; $display("FAIL sat_hold got %0b/%h exp 1/00000180", if_pred_taken_o, if_pred_target_o); end
    endtask

    task automatic test_jal();
        logic [7:0]  idx100;
        logic        tk;
        logic [31:0] tg;
        idx100 = m_idx(32'h100);
        ex_cycle(1, 0, 1, 1, 32'h200, 32'h400, 0, 32'h204, m_idx(32'h200));
        checks++; if (obs_red !== 1'b1 || obs_rpc !== 32'h400) begin errors++; $display("FAIL jal_cold got %0b/%h exp 1/00000400", obs_red, obs_rpc); end
        ex_cycle(1, 0, 1, 1, 32'h200, 32'h480, 1, 32'h400, m_idx(32'h200));
        checks++; if (obs_red !== 1'b1 || obs_rpc !== 32'h480) begin errors++; $display("FAIL jal_retarget got %0b/%h exp 1/00000480", obs_red, obs_rpc); end
        if_pc_i = 32'h100; #1;
        checks++; if (if_pht_idx_o !== idx100) begin errors++; $display("FAIL jal_ghr_kept got %h exp %h", if_pht_idx_o, idx100); end
        if_pc_i = 32'h200; #1;
        m_pred(32'h200, tk, tg);
        checks++; if (if_pred_taken_o !== tk || if_pred_target_o !== tg) begin errors++; $display("FAIL jal_fetch got %0b/%h exp %0b/%h", if_pred_taken_o, if_pred_target_o, tk, tg); end
    endtask

    task automatic test_non_branch();
        ex_cycle(1, 0, 0, 0, 32'h300, 32'h999, 1, 32'h340, m_idx(32'h300));
        checks++; if (obs_red !== 1'b1 || obs_rpc !== 32'h304) begin errors++; $display("FAIL nonbr_redirect got %0b/%h exp 1/00000304", obs_red, obs_rpc); end
        checks++; if (mispred_cnt_o !== 32'(mc) || br_cnt_o !== 32'(bc)) begin errors++; $display("FAIL nonbr_counters got %0d/%0d exp %0d/%0d", br_cnt_o, mispred_cnt_o, bc, mc); end
        ex_cycle(0, 1, 0, 1, 32'h300, 32'h340, 1, 32'h500, m_idx(32'h300));
        checks++; if (obs_red !== 1'b0 || obs_rpc !== 32'd0) begin errors++; $display("FAIL invalid_redirect got %0b/%h exp 0/0", obs_red, obs_rpc); end
        if_pc_i = 32'h300; #1;
        checks++; if (if_pred_taken_o !== 1'b0 || if_pred_target_o !== 32'h304) begin errors++; $display("FAIL nonbr_btb_untouched got %0b/%h exp 0/00000304", if_pred_taken_o, if_pred_target_o); end
        checks++; if (mispred_cnt_o !== 32'(mc) || br_cnt_o !== 32'(bc)) begin errors++; $display("FAIL invalid_counters got %0d/%0d exp %0d/%0d", br_cnt_o, mispred_cnt_o, bc, mc); end
    endtask

    task automatic test_same_cycle();
        logic        tk0, tk1;
        logic [31:0] tg0, tg1;
        if_pc_i = 32'h100;
        m_pred(32'h100, tk0, tg0);
        ex_cycle(1, 1, 0, 1, 32'h100, 32'h1C0, tk0, tg0, m_idx(32'h100));
        checks++; if (obs_if_tk !== tk0 || obs_if_tg !== tg0) begin errors++; $display("FAIL same_cycle_old got %0b/%h exp %0b/%h", obs_if_tk, obs_if_tg, tk0, tg0); end
        #1;
        m_pred(32'h100, tk1, tg1);
        checks++; if (if_pred_taken_o !== tk1 || if_pred_target_o !== tg1) begin errors++; $display("FAIL same_cycle_new got %0b/%h exp %0b/%h", if_pred_taken_o, if_pred_target_o, tk1, tg1); end
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] pc;
        pc = 32'h1000 + 32'(4 * $urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) pc = pc + 32'h100;
        return pc;
    endfunction

    task automatic test_random();
        logic [31:0] pc, tgt, fpc, ptgt, etg;
        logic        v, isbr, isunc, tk, ptk, etk;
        logic [7:0]  eidx;
        int unsigned kind;
        for (int n = 0; n < 400; n++) begin
            pc    = rand_pc();
            kind  = $urandom_range(0, 9);
            isbr  = kind <= 5;
            isunc = (kind == 6) || (kind == 7);
            v     = $urandom_range(0, 9) != 0;
            tk    = isunc ? 1'b1 : 1'($urandom_range(0, 1));
            tgt   = 32'h2000 + 32'(4 * $urandom_range(0, 3));
            m_pred(pc, ptk, ptgt);
            if ($urandom_range(0, 4) == 0) ptk = ~ptk;
            fpc = rand_pc();
            if_pc_i = fpc;
            m_pred(fpc, etk, etg);
            eidx = m_idx(fpc);
            ex_cycle(v, isbr, isunc, tk, pc, tgt, ptk, ptgt, m_idx(pc));
            checks++; if (obs_red !== exp_red || obs_rpc !== exp_rpc) begin errors++; $display("FAIL rand%0d_redirect got %0b/%h exp %0b/%h", n, obs_red, obs_rpc, exp_red, exp_rpc); end
            checks++; if (obs_if_tk !== etk || obs_if_tg !== etg || obs_if_idx !== eidx) begin errors++; $display("FAIL rand%0d_lookup got %0b/%h/%h exp %0b/%h/%h", n, obs_if_tk, obs_if_tg, obs_if_idx, etk, etg, eidx); end
            checks++; if (br_cnt_o !== 32'(bc) || mispred_cnt_o !== 32'(mc)) begin errors++; $display("FAIL rand%0d_counters got %0d/%0d exp %0d/%0d", n, br_cnt_o, mispred_cnt_o, bc, mc); end
        end
    endtask

    task automatic test_reset_mid();
        #2;
        rst_i = 1'b1; if_pc_i = 32'h100;
        #1;
        checks++; if (if_pred_taken_o !== 1'b0 || if_pred_target_o !== 32'h104) begin errors++; $display("FAIL midrst_lookup got %0b/%h exp 0/00000104", if_pred_taken_o, if_pred_target_o); end
        checks++; if (if_pht_idx_o !== 8'h40) begin errors++; $display("FAIL midrst_ghr got idx %h exp 40", if_pht_idx_o); end
        checks++; if (br_cnt_o !== 32'd0 || mispred_cnt_o !== 32'd0) begin errors++; $display("FAIL midrst_counters got %0d/%0d exp 0/0", br_cnt_o, mispred_cnt_o); end
        if_pc_i = 32'h1000; #1;
        checks++; if (if_pred_taken_o !== 1'b0) begin errors++; $display("FAIL midrst_rand_miss got %0b exp 0", if_pred_taken_o); end
        @(negedge clk_i); rst_i = 1'b0;
        model_reset();
        @(posedge clk_i); #1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_cold_branch();
        test_agree_training();
        test_pht_saturation();
        test_jal();
        test_non_branch();
        test_same_cycle();
        test_random();
        test_reset_mid();
        test_cold_branch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
